// File: rtl/safe_sync_ctrl.sv
// ---------------------------------------------------------------------------
// safe_sync_ctrl
//
// Rendezvous supervisor for a group of redundant lock-step cores. Cores raise
// a level request when they reach the sync point; each arriving core is
// halted until every participating core has arrived. The controller then
// waits DELAY_PRE cycles, pulses a one-cycle sync interrupt to all
// participants, waits DELAY_POST cycles and reports LOCKED until released.
//
// Optional feature (macro SAFE_SYNC_TIMEOUT_EN):
//   defined   - GATHER is bounded by TIMEOUT_CYCLES; expiry enters ERROR.
//   undefined - no timeout counter, GATHER waits indefinitely, timeout_o = 0.
//
// Ports
//   clk_i        in   clock, all state on rising edge
//   rst_ni       in   asynchronous active-low reset
//   enable_i     in   controller enable; low aborts a rendezvous in progress
//   core_mask_i  in   [NUM_CORES] participating cores, sampled leaving IDLE
//   sync_req_i   in   [NUM_CORES] per-core rendezvous request (level)
//   release_i    in   pulse that leaves LOCKED or ERROR
//   halt_o       out  [NUM_CORES] per-core halt (registered)
//   sync_irq_o   out  [NUM_CORES] per-core sync interrupt pulse (registered)
//   sync_done_o  out  high while LOCKED
//   timeout_o    out  high while ERROR
//   busy_o       out  high in every state except IDLE
//
// State       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a first request from a masked core
// S_GATHER    | collecting arrivals; arrived cores are halted
// S_DLY_PRE   | all arrived; settling delay before the interrupt
// S_SYNC_IRQ  | one cycle, sync interrupt to every participant
// S_DLY_POST  | settling delay after the interrupt
// S_LOCKED    | rendezvous complete, waiting for release
// S_ERROR     | rendezvous timed out, waiting for release
// ---------------------------------------------------------------------------
module safe_sync_ctrl #(
  parameter int NUM_CORES      = 3,
  parameter int DELAY_PRE      = 1,
  parameter int DELAY_POST     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [NUM_CORES-1:0] core_mask_i,
  input  logic [NUM_CORES-1:0] sync_req_i,
  input  logic                 release_i,
  output logic [NUM_CORES-1:0] halt_o,
  output logic [NUM_CORES-1:0] sync_irq_o,
  output logic                 sync_done_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  if (NUM_CORES < 2 || NUM_CORES > 8 ||
      DELAY_PRE < 0 || DELAY_PRE > 15 ||
      DELAY_POST < 0 || DELAY_POST > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("safe_sync_ctrl: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_DLY_PRE,
    S_SYNC_IRQ,
    S_DLY_POST,
    S_LOCKED,
    S_ERROR
  } state_t;

  // Delay counters hold "cycles remaining minus one", so they only need to
  // represent 0..max(DELAY)-1.
  localparam int DLY_MAX = (DELAY_PRE > DELAY_POST) ? DELAY_PRE : DELAY_POST;
  localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);
  localparam logic [DLY_W-1:0] PRE_LOAD  = DLY_W'((DELAY_PRE  > 0) ? DELAY_PRE  - 1 : 0);
  localparam logic [DLY_W-1:0] POST_LOAD = DLY_W'((DELAY_POST > 0) ? DELAY_POST - 1 : 0);

  state_t               r_state;
  logic [NUM_CORES-1:0] r_mask;
  logic [NUM_CORES-1:0] r_arrived;
  logic [DLY_W-1:0]     r_dly_cnt;
  logic [NUM_CORES-1:0] r_halt;
  logic [NUM_CORES-1:0] r_irq;
  logic                 r_done;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [NUM_CORES-1:0] w_mask_nxt;
  logic [NUM_CORES-1:0] w_arrived_nxt;
  logic [DLY_W-1:0]     w_dly_nxt;
  logic [NUM_CORES-1:0] w_gather;
  logic                 w_complete;
  logic                 w_tmo_hit;
  logic                 w_halt_state;

`ifdef SAFE_SYNC_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo;

  // Counts GATHER cycles already spent; hitting TMO_LAST means this is the
  // TIMEOUT_CYCLES-th GATHER cycle. Cleared while idle, saturates at the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_GATHER && r_tmo_cnt != TMO_LAST) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= (w_state_nxt == S_ERROR);
    end
  end

  assign timeout_o = r_tmo;
`else
  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Arrivals including requests seen this cycle; a late arrival in the same
  // cycle as timeout expiry still completes the rendezvous.
  assign w_gather   = r_arrived | (sync_req_i & r_mask);
  assign w_complete = (w_gather == r_mask);

  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_arrived_nxt = r_arrived;
    w_dly_nxt     = r_dly_cnt;

    case (r_state)
      S_IDLE: begin
        if (enable_i && |(sync_req_i & core_mask_i)) begin
          w_state_nxt   = S_GATHER;
          w_mask_nxt    = core_mask_i;
          w_arrived_nxt = sync_req_i & core_mask_i;
        end
      end

      S_GATHER: begin
        if (!enable_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_arrived_nxt = w_gather;
          if (w_complete) begin
            if (DELAY_PRE > 0) begin
              w_state_nxt = S_DLY_PRE;
              w_dly_nxt   = PRE_LOAD;
            end else begin
              w_state_nxt = S_SYNC_IRQ;
            end
          end else if (w_tmo_hit) begin
            w_state_nxt = S_ERROR;
          end
        end
      end

      S_DLY_PRE: begin
        if (!enable_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_dly_cnt == '0) begin
          w_state_nxt = S_SYNC_IRQ;
        end else begin
          w_dly_nxt = r_dly_cnt - DLY_W'(1);
        end
      end

      S_SYNC_IRQ: begin
        if (DELAY_POST > 0) begin
          w_state_nxt = S_DLY_POST;
          w_dly_nxt   = POST_LOAD;
        end else begin
          w_state_nxt = S_LOCKED;
        end
      end

      S_DLY_POST: begin
        if (!enable_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_dly_cnt == '0) begin
          w_state_nxt = S_LOCKED;
        end else begin
          w_dly_nxt = r_dly_cnt - DLY_W'(1);
        end
      end

      S_LOCKED, S_ERROR: begin
        if (release_i) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Arrival history only lives for one rendezvous.
    if (w_state_nxt == S_IDLE) begin
      w_arrived_nxt = '0;
    end
  end

  assign w_halt_state = (w_state_nxt == S_GATHER)   || (w_state_nxt == S_DLY_PRE) ||
                        (w_state_nxt == S_SYNC_IRQ) || (w_state_nxt == S_DLY_POST);

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_arrived <= '0;
      r_dly_cnt <= '0;
      r_halt    <= '0;
      r_irq     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_arrived <= w_arrived_nxt;
      r_dly_cnt <= w_dly_nxt;
      r_halt    <= w_halt_state ? w_arrived_nxt : '0;
      r_irq     <= (w_state_nxt == S_SYNC_IRQ) ? w_mask_nxt : '0;
      r_done    <= (w_state_nxt == S_LOCKED);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign halt_o      = r_halt;
  assign sync_irq_o  = r_irq;
  assign sync_done_o = r_done;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_safe_sync_ctrl.sv
module tb_safe_sync_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;

  logic       en_a = 1'b0, rel_a = 1'b0;
  logic [2:0] mask_a = '0, req_a = '0;
  logic [2:0] halt_a, irq_a;
  logic       done_a, tmo_a, busy_a;

  logic       en_b = 1'b0, rel_b = 1'b0;
  logic [2:0] mask_b = '0, req_b = '0;
  logic [2:0] halt_b, irq_b;
  logic       done_b, tmo_b, busy_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    bit         d;
    string      nm;
    logic [8:0] v;   // {halt, irq, done, timeout, busy}
  } exp_t;

  exp_t q[$];

  safe_sync_ctrl #(
    .NUM_CORES(3), .DELAY_PRE(1), .DELAY_POST(1), .TIMEOUT_CYCLES(16)
  ) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(en_a), .core_mask_i(mask_a),
    .sync_req_i(req_a), .release_i(rel_a), .halt_o(halt_a), .sync_irq_o(irq_a),
    .sync_done_o(done_a), .timeout_o(tmo_a), .busy_o(busy_a)
  );

  safe_sync_ctrl #(
    .NUM_CORES(3), .DELAY_PRE(0), .DELAY_POST(0), .TIMEOUT_CYCLES(1024)
  ) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(en_b), .core_mask_i(mask_b),
    .sync_req_i(req_b), .release_i(rel_b), .halt_o(halt_b), .sync_irq_o(irq_b),
    .sync_done_o(done_b), .timeout_o(tmo_b), .busy_o(busy_b)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // One cycle of stimulus for DUT d (the other DUT is held idle), plus the
  // hand-computed outputs expected during that same cycle.
  task automatic step(input string nm, input bit d, input bit rst, input bit en,
                      input logic [2:0] msk, input logic [2:0] req, input bit rel,
                      input logic [2:0] eh, input logic [2:0] ei,
                      input bit ed, input bit et, input bit eb);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni = rst;
    if (d) begin
      en_b = en; mask_b = msk; req_b = req; rel_b = rel;
      en_a = 1'b0; mask_a = '0; req_a = '0; rel_a = 1'b0;
    end else begin
      en_a = en; mask_a = msk; req_a = req; rel_a = rel;
      en_b = 1'b0; mask_b = '0; req_b = '0; rel_b = 1'b0;
    end
    e.cyc = cyc;
    e.d   = d;
    e.nm  = nm;
    e.v   = {eh, ei, ed, et, eb};
    q.push_back(e);
  endtask

  // Monitor: at mid-cycle, pop every expectation due for this cycle.
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk_i);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = e.d ? {halt_b, irq_b, done_b, tmo_b, busy_b}
                  : {halt_a, irq_a, done_a, tmo_a, busy_a};
        checks++;
        if (e.cyc != cyc || act !== e.v) begin
          errors++;
          $display("FAIL %s (cycle %0d): got halt=%b irq=%b done=%b tmo=%b busy=%b, want halt=%b irq=%b done=%b tmo=%b busy=%b",
                   e.nm, e.cyc, act[8:6], act[5:3], act[2], act[1], act[0],
                   e.v[8:6], e.v[5:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin
    // reset
    step("rst_hold", 0, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);
    step("rst_rel",  0, 1, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

    // all cores at once; release pulse during DLY_PRE must be ignored
    step("s1_c0", 0, 1, 1, 3'b111, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s1_c1", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s1_c2", 0, 1, 1, 3'b111, 3'b000, 1, 3'b111, 3'b000, 0, 0, 1);
    step("s1_c3", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b111, 0, 0, 1);
    step("s1_c4", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s1_c5", 0, 1, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 1, 0, 1);
    step("s1_c6", 0, 1, 0, 3'b111, 3'b000, 1, 3'b000, 3'b000, 1, 0, 1);
    step("s1_c7", 0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

    // staggered arrivals; core0 drops its request, arrival stays sticky
    step("s2_c0", 0, 1, 1, 3'b111, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s2_c1", 0, 1, 1, 3'b111, 3'b001, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s2_c2", 0, 1, 1, 3'b111, 3'b000, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s2_c3", 0, 1, 1, 3'b111, 3'b000, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s2_c4", 0, 1, 1, 3'b111, 3'b010, 0, 3'b001, 3'b000, 0, 0, 1);
    for (int i = 5; i <= 8; i++)
      step($sformatf("s2_c%0d", i), 0, 1, 1, 3'b111, 3'b000, 0, 3'b011, 3'b000, 0, 0, 1);
    step("s2_c9",  0, 1, 1, 3'b111, 3'b100, 0, 3'b011, 3'b000, 0, 0, 1);
    step("s2_c10", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s2_c11", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b111, 0, 0, 1);
    step("s2_c12", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s2_c13", 0, 1, 1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 1, 0, 1);
    step("s2_c14", 0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

    // disabled controller ignores requests; partial mask 101
    step("s3_dis",  0, 1, 0, 3'b111, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s3_c1",   0, 1, 1, 3'b101, 3'b010, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s3_c2",   0, 1, 1, 3'b101, 3'b010, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s3_c3",   0, 1, 1, 3'b101, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s3_c4",   0, 1, 1, 3'b101, 3'b111, 0, 3'b101, 3'b000, 0, 0, 1);
    step("s3_c5",   0, 1, 1, 3'b101, 3'b010, 0, 3'b101, 3'b000, 0, 0, 1);
    step("s3_c6",   0, 1, 1, 3'b101, 3'b010, 0, 3'b101, 3'b101, 0, 0, 1);
    step("s3_c7",   0, 1, 1, 3'b101, 3'b000, 0, 3'b101, 3'b000, 0, 0, 1);
    step("s3_c8",   0, 1, 1, 3'b101, 3'b000, 1, 3'b000, 3'b000, 1, 0, 1);
    step("s3_c9",   0, 1, 1, 3'b101, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

    // enable dropped in DLY_PRE: back to IDLE, no interrupt
    step("s4_c0", 0, 1, 1, 3'b111, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s4_c1", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s4_c2", 0, 1, 0, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s4_c3", 0, 1, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s4_c4", 0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

    // asynchronous reset in DLY_POST clears outputs within the cycle
    step("s5_c0",  0, 1, 1, 3'b111, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s5_c1",  0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s5_c2",  0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s5_c3",  0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b111, 0, 0, 1);
    step("s5_rst", 0, 0, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s5_c5",  0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s5_c6",  0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

`ifdef SAFE_SYNC_TIMEOUT_EN
    // only core0 arrives: 16 GATHER cycles, then ERROR until release
    step("s6_c0", 0, 1, 1, 3'b111, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0);
    for (int i = 1; i <= 16; i++)
      step($sformatf("s6_c%0d", i), 0, 1, 1, 3'b111, 3'b000, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s6_err", 0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 1, 1);
    step("s6_rel", 0, 1, 1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 1, 1);
    step("s6_idl", 0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

    // completion in the expiry cycle wins over the timeout
    step("s7_c0", 0, 1, 1, 3'b111, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0);
    for (int i = 1; i <= 15; i++)
      step($sformatf("s7_c%0d", i), 0, 1, 1, 3'b111, 3'b000, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s7_c16", 0, 1, 1, 3'b111, 3'b110, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s7_c17", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s7_c18", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b111, 0, 0, 1);
    step("s7_c19", 0, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s7_c20", 0, 1, 1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 1, 0, 1);
    step("s7_c21", 0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);
`else
    // no timeout: GATHER keeps waiting well past 16 cycles
    step("s6_c0", 0, 1, 1, 3'b111, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0);
    for (int i = 1; i <= 19; i++)
      step($sformatf("s6_c%0d", i), 0, 1, 1, 3'b111, 3'b000, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s6_c20", 0, 1, 0, 3'b111, 3'b000, 0, 3'b001, 3'b000, 0, 0, 1);
    step("s6_c21", 0, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);
`endif

    // zero-delay instance: SYNC_IRQ right after completion, LOCKED next
    step("s8_c0", 1, 1, 1, 3'b111, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0);
    step("s8_c1", 1, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b000, 0, 0, 1);
    step("s8_c2", 1, 1, 1, 3'b111, 3'b000, 0, 3'b111, 3'b111, 0, 0, 1);
    step("s8_c3", 1, 1, 1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 1, 0, 1);
    step("s8_c4", 1, 1, 1, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0);

    repeat (3) @(posedge clk_i);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
